// File: rtl/traffic_pkg.sv
// traffic_pkg: controller state encoding and per-road light codes shared by the traffic-light design
package traffic_pkg;
  typedef enum logic [2:0] {
    A_GREEN,
    A_YELLOW,
    B_GREEN,
    B_YELLOW,
    MAN_A,
    MAN_B,
    ALL_RED
  } state_t;
  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;
endpackage

// File: rtl/bin2bcd99.sv
// bin2bcd99: combinational 7-bit binary (0..99) to BCD; bin in, tens/units digits out
module bin2bcd99 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);
  assign tens  = 4'(bin / 7'd10);
  assign units = 4'(bin % 7'd10);
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road light sequencer; Clk/Rst, per-road Force/Traffic in, per-road Light and BCD countdown out, Manual flag
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int GREEN_TIME  = 30,
  parameter int YELLOW_TIME = 3,
  parameter int EXT_TIME    = 10,
  parameter int MAX_EXT     = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       A_Force,
  input  logic       B_Force,
  input  logic       A_Traffic,
  input  logic       B_Traffic,
  output logic [1:0] A_Light,
  output logic [1:0] B_Light,
  output logic [3:0] A_Time_H,
  output logic [3:0] A_Time_L,
  output logic [3:0] B_Time_H,
  output logic [3:0] B_Time_L,
  output logic       Manual
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0] G_T = 7'(GREEN_TIME);
  localparam logic [6:0] Y_T = 7'(YELLOW_TIME);
  localparam logic [6:0] E_T = 7'(EXT_TIME);
  localparam logic [7:0] X_MAX = 8'(MAX_EXT);
  state_t state_q, state_d, tgt, own_man, own_green, yel, oth_green;
  logic [6:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_x;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0] ext_q, ext_d;
  logic tick, has_tgt, x_a, trf_x, trf_o;
  // x_a: road A is the non-red road (green, yellow or manual green)
  always_comb begin
    tick = presc_q == P_LAST;
    has_tgt = A_Force | B_Force;
    tgt = (A_Force && B_Force) ? ALL_RED : A_Force ? MAN_A : MAN_B;
    x_a = state_q inside {A_GREEN, A_YELLOW, MAN_A};
    own_man = x_a ? MAN_A : MAN_B;
    own_green = x_a ? A_GREEN : B_GREEN;
    yel = x_a ? A_YELLOW : B_YELLOW;
    oth_green = x_a ? B_GREEN : A_GREEN;
    cnt_x = x_a ? cnt_a_q : cnt_b_q;
    trf_x = x_a ? A_Traffic : B_Traffic;
    trf_o = x_a ? B_Traffic : A_Traffic;
    state_d = state_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    ext_d = ext_q;
    case (state_q)
      A_GREEN, B_GREEN:
        if (has_tgt) state_d = (tgt == own_man) ? own_man : yel;
        else if (tick && cnt_x == 7'd1 && !(trf_x && !trf_o && ext_q < X_MAX)) state_d = yel;
        else if (tick && cnt_x == 7'd1) begin
          ext_d = ext_q + 8'd1;
          cnt_a_d = x_a ? E_T : E_T + Y_T;
          cnt_b_d = x_a ? E_T + Y_T : E_T;
        end else if (tick) begin
          cnt_a_d = cnt_a_q - 7'd1;
          cnt_b_d = cnt_b_q - 7'd1;
        end
      // a yellow toward another target runs to completion before the target is re-evaluated
      A_YELLOW, B_YELLOW:
        if (has_tgt && tgt == own_man) state_d = own_man;
        else if (tick && cnt_x == 7'd1) state_d = has_tgt ? tgt : oth_green;
        else if (tick) begin
          cnt_a_d = cnt_a_q - 7'd1;
          cnt_b_d = cnt_b_q - 7'd1;
        end
      MAN_A, MAN_B: state_d = !has_tgt ? own_green : (tgt == own_man) ? own_man : yel;
      // both roads already red, so any manual target is safe to enter directly
      ALL_RED: state_d = has_tgt ? tgt : A_GREEN;
      default: state_d = A_GREEN;
    endcase
    // every state entry reloads counters from the state being entered
    if (state_d != state_q) begin
      cnt_a_d = state_d == A_GREEN ? G_T : state_d == B_GREEN ? G_T + Y_T :
                state_d inside {A_YELLOW, B_YELLOW} ? Y_T : 7'd0;
      cnt_b_d = state_d == B_GREEN ? G_T : state_d == A_GREEN ? G_T + Y_T :
                state_d inside {A_YELLOW, B_YELLOW} ? Y_T : 7'd0;
      ext_d = 8'd0;
    end
    presc_d = (state_d != state_q || tick) ? '0 : presc_q + 1'b1;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= A_GREEN;
      cnt_a_q <= G_T;
      cnt_b_q <= G_T + Y_T;
      presc_q <= '0;
      ext_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      presc_q <= presc_d;
      ext_q <= ext_d;
    end
  end
  assign A_Light = state_q inside {A_GREEN, MAN_A} ? LIGHT_GREEN : state_q == A_YELLOW ? LIGHT_YELLOW : LIGHT_RED;
  assign B_Light = state_q inside {B_GREEN, MAN_B} ? LIGHT_GREEN : state_q == B_YELLOW ? LIGHT_YELLOW : LIGHT_RED;
  assign Manual = state_q inside {MAN_A, MAN_B, ALL_RED};
  bin2bcd99 u_bcd_a (.bin(cnt_a_q), .tens(A_Time_H), .units(A_Time_L));
  bin2bcd99 u_bcd_b (.bin(cnt_b_q), .tens(B_Time_H), .units(B_Time_L));
endmodule
